// File: rtl/led_display_arbiter_pkg.sv
// Shared definitions for the LED display arbiter.
// Contents:
//   - FSM state encoding
//   - requester index constants
//   - digit enable patterns
//   - a one-hot word selector
package led_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    LINGER,
    GAP
  } arb_state_t;

  localparam int unsigned REQ_KEY = 0;
  localparam int unsigned REQ_RES = 1;
  localparam int unsigned REQ_ERR = 2;

  localparam logic [3:0] DIGITS_ON  = 4'b1111;
  localparam logic [3:0] DIGITS_OFF = 4'b0000;

  // Selects the display word of a one-hot requester; zero when none is selected.
  function automatic logic [15:0] pick_word(input logic [2:0]  sel,
                                            input logic [15:0] d0,
                                            input logic [15:0] d1,
                                            input logic [15:0] d2);
    logic [15:0] w;
    w = '0;
    if (sel[REQ_ERR])      w = d2;
    else if (sel[REQ_RES]) w = d1;
    else if (sel[REQ_KEY]) w = d0;
    return w;
  endfunction

endpackage

// File: rtl/led_display_arbiter_prio_enc.sv
// Fixed-priority encoder for the display arbiter (requester 2 highest).
// Ports:
//   req    in  3  level requests
//   winner out 3  one-hot highest active request, 000 when none
//   valid  out 1  any request active
module led_prio_enc
  import led_arb_pkg::*;
(
  input  logic [2:0] req,
  output logic [2:0] winner,
  output logic       valid
);

  always_comb begin
    winner = '0;
    if (req[REQ_ERR])      winner[REQ_ERR] = 1'b1;
    else if (req[REQ_RES]) winner[REQ_RES] = 1'b1;
    else if (req[REQ_KEY]) winner[REQ_KEY] = 1'b1;
    valid = |req;
  end

endmodule

// File: rtl/led_display_arbiter.sv
// Time-shares a 4-digit scanned LED display between three requesters
// (0 keypad echo, 1 calculator result, 2 error/status) with fixed priority,
// minimum hold time, a blank gap between owners and blinking for owner 2.
// Ports:
//   ledClk              in   scan clock, posedge
//   reset               in   asynchronous, active-low
//   req[2:0]            in   level request per requester
//   data0/data1/data2   in   16-bit display words, [15:12] leftmost digit
//   num1..num4          out  digit nibbles, num1 leftmost
//   digit_en[3:0]       out  per-digit enable, [3] = num1, 0 = dark
//   grant[2:0]          out  one-hot current owner
//   busy                out  high whenever not IDLE
module led_display_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned HOLD_TICKS  = 250,
  parameter int unsigned BLANK_TICKS = 2,
  parameter int unsigned BLINK_TICKS = 125
) (
  input  logic        ledClk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [3:0]  num1,
  output logic [3:0]  num2,
  output logic [3:0]  num3,
  output logic [3:0]  num4,
  output logic [3:0]  digit_en,
  output logic [2:0]  grant,
  output logic        busy
);

  localparam int unsigned MAX_HB  = (HOLD_TICKS > BLANK_TICKS) ? HOLD_TICKS : BLANK_TICKS;
  localparam int unsigned MAX_ALL = (MAX_HB > BLINK_TICKS) ? MAX_HB : BLINK_TICKS;
  localparam int unsigned CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(HOLD_TICKS);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] BLNK_LAST = CW'(BLINK_TICKS - 1);

  arb_state_t    state;
  logic [2:0]    owner;
  logic [CW-1:0] cnt;
  logic [CW-1:0] bcnt;

  logic [2:0]    win;
  logic          win_valid;
  logic [15:0]   win_word;
  logic [15:0]   own_word;
  logic          own_req;
  logic          other_req;
  logic          higher_req;
  logic [CW-1:0] bcnt_next;
  logic [3:0]    en_next;

  led_prio_enc u_prio_enc (
    .req    (req),
    .winner (win),
    .valid  (win_valid)
  );

  always_comb begin
    win_word   = pick_word(win, data0, data1, data2);
    own_word   = pick_word(owner, data0, data1, data2);
    own_req    = |(req & owner);
    other_req  = |(req & ~owner);
    higher_req = (owner[REQ_KEY] & (req[REQ_RES] | req[REQ_ERR])) |
                 (owner[REQ_RES] & req[REQ_ERR]);
    // Blink advance for one displayed tick; non-error owners stay steady on.
    bcnt_next = bcnt;
    en_next   = DIGITS_ON;
    if (owner[REQ_ERR]) begin
      en_next = digit_en;
      if (bcnt == BLNK_LAST) begin
        bcnt_next = '0;
        en_next   = ~digit_en;
      end else begin
        bcnt_next = bcnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge ledClk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= '0;
      cnt      <= '0;
      bcnt     <= '0;
      num1     <= '0;
      num2     <= '0;
      num3     <= '0;
      num4     <= '0;
      digit_en <= DIGITS_OFF;
      grant    <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state    <= SHOW;
            owner    <= win;
            grant    <= win;
            busy     <= 1'b1;
            cnt      <= '0;
            bcnt     <= '0;
            digit_en <= DIGITS_ON;
            {num1, num2, num3, num4} <= win_word;
          end
        end

        SHOW: begin
          if (!own_req && other_req) begin
            state    <= GAP;
            grant    <= '0;
            digit_en <= DIGITS_OFF;
            cnt      <= '0;
          end else if (!own_req) begin
            // Display words are frozen from here; the blink keeps running.
            state    <= LINGER;
            cnt      <= '0;
            bcnt     <= bcnt_next;
            digit_en <= en_next;
          end else if (higher_req && (cnt >= HOLD_MAX)) begin
            state    <= GAP;
            grant    <= '0;
            digit_en <= DIGITS_OFF;
            cnt      <= '0;
          end else begin
            {num1, num2, num3, num4} <= own_word;
            if (cnt < HOLD_MAX) cnt <= cnt + CNT_ONE;
            bcnt     <= bcnt_next;
            digit_en <= en_next;
          end
        end

        LINGER: begin
          if (win_valid) begin
            state    <= GAP;
            grant    <= '0;
            digit_en <= DIGITS_OFF;
            cnt      <= '0;
          end else if (cnt == HOLD_LAST) begin
            state    <= IDLE;
            owner    <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            digit_en <= DIGITS_OFF;
            cnt      <= '0;
          end else begin
            cnt      <= cnt + CNT_ONE;
            bcnt     <= bcnt_next;
            digit_en <= en_next;
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (win_valid) begin
              state    <= SHOW;
              owner    <= win;
              grant    <= win;
              bcnt     <= '0;
              digit_en <= DIGITS_ON;
              {num1, num2, num3, num4} <= win_word;
            end else begin
              state <= IDLE;
              owner <= '0;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Directed self-checking bench for led_display_arbiter.
// Outputs are sampled 1 time unit after each rising edge; inputs change there too.
module tb_led_display_arbiter;

  logic        ledClk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [15:0] data0, data1, data2;
  logic [3:0]  num1, num2, num3, num4;
  logic [3:0]  digit_en;
  logic [2:0]  grant;
  logic        busy;

  int tests = 0;
  int fails = 0;

  // {grant, busy, digit_en, num1..num4}
  logic [23:0] obs;
  assign obs = {grant, busy, digit_en, num1, num2, num3, num4};

  led_display_arbiter #(
    .HOLD_TICKS  (4),
    .BLANK_TICKS (2),
    .BLINK_TICKS (3)
  ) dut (
    .ledClk   (ledClk),
    .reset    (reset),
    .req      (req),
    .data0    (data0),
    .data1    (data1),
    .data2    (data2),
    .num1     (num1),
    .num2     (num2),
    .num3     (num3),
    .num4     (num4),
    .digit_en (digit_en),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 ledClk = ~ledClk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ledClk);
      #1;
    end
  endtask

  task automatic test_reset;
    logic [23:0] exp;
    reset = 1'b0;
    req   = 3'b000;
    data0 = 16'h0000;
    data1 = 16'h0000;
    data2 = 16'h0000;
    tick(2);
    exp = '0;
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL reset_state: got %h expected %h", obs, exp);
    end
    reset = 1'b1;
    tick(1);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL idle_no_req: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_basic_and_linger;
    logic [23:0] exp;
    logic [7:0]  exp_ctl;
    data1 = 16'h1234;
    req   = 3'b010;
    tick(1);
    exp = {3'b010, 1'b1, 4'hF, 16'h1234};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL basic_grant: got %h expected %h", obs, exp);
    end
    tick(5);
    req = 3'b000;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL linger_tick%0d: got %h expected %h", i, obs, exp);
      end
    end
    tick(1);
    exp_ctl = {3'b000, 1'b0, 4'h0};
    tests++;
    if (obs[23:16] !== exp_ctl) begin
      fails++;
      $display("FAIL linger_to_idle: got %h expected %h", obs[23:16], exp_ctl);
    end
  endtask

  task automatic test_hold_protection;
    logic [23:0] exp;
    logic [7:0]  exp_ctl;
    data0 = 16'h0007;
    data2 = 16'hEEEE;
    req   = 3'b001;
    tick(1);
    exp = {3'b001, 1'b1, 4'hF, 16'h0007};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL hold_grant0: got %h expected %h", obs, exp);
    end
    req = 3'b101;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL hold_keep%0d: got %h expected %h", i, obs, exp);
      end
    end
    exp_ctl = {3'b000, 1'b1, 4'h0};
    for (int i = 0; i < 2; i++) begin
      tick(1);
      tests++;
      if (obs[23:16] !== exp_ctl) begin
        fails++;
        $display("FAIL hold_gap%0d: got %h expected %h", i, obs[23:16], exp_ctl);
      end
    end
    tick(1);
    exp = {3'b100, 1'b1, 4'hF, 16'hEEEE};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL hold_handover: got %h expected %h", obs, exp);
    end
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      tests++;
      if (grant !== 3'b100) begin
        fails++;
        $display("FAIL no_low_preempt%0d: got %b expected %b", i, grant, 3'b100);
      end
    end
    req = 3'b000;
    tick(6);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL hold_back_idle: got %b expected %b", busy, 1'b0);
    end
  endtask

  task automatic test_blink;
    logic [3:0] exp_en;
    data2 = 16'hEEEE;
    req   = 3'b100;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      exp_en = (((i / 3) % 2) == 1) ? 4'h0 : 4'hF;
      tests++;
      if ({digit_en, num1, num2, num3, num4} !== {exp_en, 16'hEEEE}) begin
        fails++;
        $display("FAIL blink%0d: got %h %h%h%h%h expected %h eeee",
                 i, digit_en, num1, num2, num3, num4, exp_en);
      end
    end
    req = 3'b000;
    tick(6);
  endtask

  task automatic test_simultaneous;
    logic [23:0] exp;
    logic [7:0]  exp_ctl;
    data0 = 16'h0007;
    data1 = 16'h1234;
    req   = 3'b010;
    tick(5);
    req = 3'b001;
    exp_ctl = {3'b000, 1'b1, 4'h0};
    for (int i = 0; i < 2; i++) begin
      tick(1);
      tests++;
      if (obs[23:16] !== exp_ctl) begin
        fails++;
        $display("FAIL simul_gap%0d: got %h expected %h", i, obs[23:16], exp_ctl);
      end
    end
    tick(1);
    exp = {3'b001, 1'b1, 4'hF, 16'h0007};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL simul_handover: got %h expected %h", obs, exp);
    end
    req = 3'b000;
    tick(6);
  endtask

  task automatic test_reset_mid_gap;
    logic [23:0] exp;
    data0 = 16'h0007;
    data1 = 16'h1234;
    req   = 3'b010;
    tick(2);
    req = 3'b001;
    tick(1);
    #2;
    reset = 1'b0;
    #1;
    exp = '0;
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL async_reset: got %h expected %h", obs, exp);
    end
    tick(1);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL reset_held: got %h expected %h", obs, exp);
    end
    reset = 1'b1;
    tick(1);
    exp = {3'b001, 1'b1, 4'hF, 16'h0007};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL post_reset_grant: got %h expected %h", obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_and_linger();
    test_hold_protection();
    test_blink();
    test_simultaneous();
    test_reset_mid_gap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
